// File: rtl/chamber_tree_pkg.sv
// Shared definitions for the chamber merge-tree sequencer: FSM encodings,
// heap-tree helpers and phase-duration conversion.
package chamber_tree_pkg;

  // Upper bound on tree size that the helper functions can handle.
  localparam int MAX_LEAVES = 64;
  localparam int MAX_NODES  = 2 * MAX_LEAVES - 1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FILL  = 3'd1;
  localparam state_t ST_MIX   = 3'd2;
  localparam state_t ST_XFER  = 3'd3;
  localparam state_t ST_DRAIN = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // Timer reload values for the default phase durations.
  localparam int FILL_LOAD_DEF  = 3;
  localparam int MIX_LOAD_DEF   = 2;
  localparam int XFER_LOAD_DEF  = 1;
  localparam int DRAIN_LOAD_DEF = 4;

  // A phase of N cycles loads N-1 and ends on the cycle the timer reads 0.
  function automatic int phase_load(input int cycles);
    return cycles - 1;
  endfunction

  // Depth of heap node n, i.e. floor(log2(n+1)).
  function automatic int node_depth(input int n);
    int d;
    d = 0;
    for (int k = 1; k < 31; k++) begin
      if ((n + 1) >= (1 << k)) d = k;
    end
    return d;
  endfunction

  // A node is active when any selected leaf lies beneath it.
  function automatic logic [MAX_NODES-1:0] active_nodes(input logic [MAX_LEAVES-1:0] mask,
                                                        input int leaves);
    logic [MAX_NODES-1:0] act;
    act = '0;
    for (int i = 0; i < MAX_LEAVES; i++) begin
      if (i < leaves) act[leaves-1+i] = mask[i];
    end
    for (int n = MAX_LEAVES - 2; n >= 0; n--) begin
      if (n < leaves - 1) act[n] = act[2*n+1] | act[2*n+2];
    end
    return act;
  endfunction

endpackage

// File: rtl/chamber_tree_sequencer_phase_timer.sv
// Loadable down-counter that times each sequencer phase; holds at zero.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] value_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/chamber_tree_sequencer.sv
// Sequencer for a binary merge tree of chambers: fill leaves, mix and transfer
// level by level toward the root, then drain. All outputs are Moore-decoded.
module chamber_tree_sequencer
  import chamber_tree_pkg::*;
#(
  parameter int LEAVES       = 8,
  parameter int FILL_CYCLES  = 4,
  parameter int MIX_CYCLES   = 3,
  parameter int XFER_CYCLES  = 2,
  parameter int DRAIN_CYCLES = 5,
  parameter int CNT_W        = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [LEAVES-1:0]          leaf_mask,
  input  logic                       abort,
  output logic [LEAVES-1:0]          fill_open,
  output logic [2*LEAVES-2:0]        mix_on,
  output logic [2*LEAVES-3:0]        xfer_open,
  output logic                       drain_open,
  output logic                       busy,
  output logic [$clog2(LEAVES):0]    level,
  output logic                       done,
  output logic                       aborted,
  output logic                       err
);

  localparam int DEPTH = $clog2(LEAVES);
  localparam int NODES = 2 * LEAVES - 1;
  localparam int LW    = DEPTH + 1;

  localparam logic [CNT_W-1:0] FILL_LOAD  = CNT_W'(phase_load(FILL_CYCLES));
  localparam logic [CNT_W-1:0] MIX_LOAD   = CNT_W'(phase_load(MIX_CYCLES));
  localparam logic [CNT_W-1:0] XFER_LOAD  = CNT_W'(phase_load(XFER_CYCLES));
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(phase_load(DRAIN_CYCLES));

  state_t           state_q, state_d;
  logic [LW-1:0]    level_q, level_d;
  logic [NODES-1:0] active_q, active_d;
  logic             err_q, err_d;
  logic             aborted_q, aborted_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_zero;
  logic             unused_tmr_value;

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_phase_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_load_val),
    .value_o   (tmr_value),
    .zero_o    (tmr_zero)
  );

  assign unused_tmr_value = ^tmr_value;

  // Abort outranks every transition, including a start that arrives in IDLE.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    active_d     = active_q;
    err_d        = 1'b0;
    aborted_d    = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;

    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      level_d   = '0;
      active_d  = '0;
      aborted_d = 1'b1;
      tmr_load  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            if (leaf_mask == '0) begin
              err_d = 1'b1;
            end else begin
              state_d      = ST_FILL;
              level_d      = LW'(DEPTH);
              active_d     = NODES'(active_nodes(MAX_LEAVES'(leaf_mask), LEAVES));
              tmr_load     = 1'b1;
              tmr_load_val = FILL_LOAD;
            end
          end
        end
        ST_FILL: begin
          if (tmr_zero) begin
            state_d      = ST_MIX;
            tmr_load     = 1'b1;
            tmr_load_val = MIX_LOAD;
          end
        end
        ST_MIX: begin
          if (tmr_zero) begin
            tmr_load = 1'b1;
            if (level_q == '0) begin
              state_d      = ST_DRAIN;
              tmr_load_val = DRAIN_LOAD;
            end else begin
              state_d      = ST_XFER;
              tmr_load_val = XFER_LOAD;
            end
          end
        end
        ST_XFER: begin
          if (tmr_zero) begin
            state_d      = ST_MIX;
            level_d      = level_q - 1'b1;
            tmr_load     = 1'b1;
            tmr_load_val = MIX_LOAD;
          end
        end
        ST_DRAIN: begin
          if (tmr_zero) state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d  = ST_IDLE;
          level_d  = '0;
          active_d = '0;
        end
        default: begin
          state_d  = ST_IDLE;
          level_d  = '0;
          active_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      level_q   <= '0;
      active_q  <= '0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      active_q  <= active_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  // Valve/mixer decode: only active nodes at the current depth are driven.
  always_comb begin
    fill_open  = '0;
    mix_on     = '0;
    xfer_open  = '0;
    drain_open = 1'b0;
    case (state_q)
      ST_FILL: fill_open = active_q[LEAVES-1 +: LEAVES];
      ST_MIX: begin
        for (int n = 0; n < NODES; n++) begin
          mix_on[n] = active_q[n] && (node_depth(n) == int'(level_q));
        end
      end
      ST_XFER: begin
        for (int k = 1; k < NODES; k++) begin
          xfer_open[k-1] = active_q[k] && (node_depth(k) == int'(level_q));
        end
      end
      ST_DRAIN: drain_open = 1'b1;
      default: ;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign level   = level_q;
  assign err     = err_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_chamber_tree_sequencer.sv
// Directed self-checking bench for chamber_tree_sequencer (8-leaf and 4-leaf trees).
module tb_chamber_tree_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start8 = 1'b0, abort8 = 1'b0;
  logic [7:0]  mask8 = '0;
  logic [7:0]  fill8;
  logic [14:0] mix8;
  logic [13:0] xfer8;
  logic        drain8, busy8, done8, aborted8, err8;
  logic [3:0]  level8;

  logic        start4 = 1'b0, abort4 = 1'b0;
  logic [3:0]  mask4 = '0;
  logic [3:0]  fill4;
  logic [6:0]  mix4;
  logic [5:0]  xfer4;
  logic        drain4, busy4, done4, aborted4, err4;
  logic [2:0]  level4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chamber_tree_sequencer #(.LEAVES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .leaf_mask(mask8), .abort(abort8),
    .fill_open(fill8), .mix_on(mix8), .xfer_open(xfer8), .drain_open(drain8),
    .busy(busy8), .level(level8), .done(done8), .aborted(aborted8), .err(err8)
  );

  chamber_tree_sequencer #(.LEAVES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .leaf_mask(mask4), .abort(abort4),
    .fill_open(fill4), .mix_on(mix4), .xfer_open(xfer4), .drain_open(drain4),
    .busy(busy4), .level(level4), .done(done4), .aborted(aborted4), .err(err4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Expected phase (0 idle,1 fill,2 mix,3 xfer,4 drain,5 done) and level for cycle t0+c.
  task automatic expPhase(input int c, input int depth, output int ph, output int lv);
    int idx;
    ph = 0;
    lv = 0;
    if (c >= 1 && c <= 4) begin
      ph = 1;
      lv = depth;
    end else if (c > 4) begin
      idx = c - 5;
      for (int d = depth; d >= 1; d--) begin
        if (ph == 0) begin
          if (idx < 3) begin
            ph = 2; lv = d;
          end else begin
            idx -= 3;
            if (idx < 2) begin
              ph = 3; lv = d;
            end else begin
              idx -= 2;
            end
          end
        end
      end
      if (ph == 0) begin
        if (idx < 3) ph = 2;
        else begin
          idx -= 3;
          if (idx < 5) ph = 4;
          else if (idx == 5) ph = 5;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] m, input logic a);
    @(negedge clk);
    start8 = s;
    mask8  = m;
    abort8 = a;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    abort8 = 1'b0;
  endtask

  task automatic checkIdle8(input string tag);
    checkOutput({tag, " fill"},  32'(fill8),  32'h0);
    checkOutput({tag, " mix"},   32'(mix8),   32'h0);
    checkOutput({tag, " xfer"},  32'(xfer8),  32'h0);
    checkOutput({tag, " drain"}, 32'(drain8), 32'h0);
    checkOutput({tag, " busy"},  32'(busy8),  32'h0);
    checkOutput({tag, " level"}, 32'(level8), 32'h0);
    checkOutput({tag, " done"},  32'(done8),  32'h0);
  endtask

  task automatic run8(input string tag, input logic [7:0] mask, input int pulseAt,
                      input logic [14:0] m0, input logic [14:0] m1, input logic [14:0] m2,
                      input logic [14:0] m3, input logic [13:0] x1, input logic [13:0] x2,
                      input logic [13:0] x3);
    logic [14:0] mixTab [4];
    logic [13:0] xferTab [4];
    int ph, lv;
    mixTab[0] = m0; mixTab[1] = m1; mixTab[2] = m2; mixTab[3] = m3;
    xferTab[0] = '0; xferTab[1] = x1; xferTab[2] = x2; xferTab[3] = x3;
    applyStimulus(1'b1, mask, 1'b0);
    for (int c = 1; c <= 29; c++) begin
      @(negedge clk);
      if (c == pulseAt + 1) start8 = 1'b0;
      expPhase(c, 3, ph, lv);
      checkOutput($sformatf("%s fill c%0d", tag, c),  32'(fill8),  32'((ph == 1) ? mask : 8'h00));
      checkOutput($sformatf("%s mix c%0d", tag, c),   32'(mix8),   32'((ph == 2) ? mixTab[lv] : 15'h0));
      checkOutput($sformatf("%s xfer c%0d", tag, c),  32'(xfer8),  32'((ph == 3) ? xferTab[lv] : 14'h0));
      checkOutput($sformatf("%s drain c%0d", tag, c), 32'(drain8), 32'(ph == 4));
      checkOutput($sformatf("%s busy c%0d", tag, c),  32'(busy8),  32'(ph != 0));
      checkOutput($sformatf("%s done c%0d", tag, c),  32'(done8),  32'(ph == 5));
      checkOutput($sformatf("%s level c%0d", tag, c), 32'(level8), 32'(lv));
      checkOutput($sformatf("%s err c%0d", tag, c),   32'(err8),   32'h0);
      if (c == pulseAt) begin
        start8 = 1'b1;
        mask8  = 8'hFF;
      end
    end
  endtask

  initial begin
    int ph, lv;
    logic [6:0] mix4Tab [3];
    logic [5:0] xfer4Tab [3];

    $display("[TB] starting chamber_tree_sequencer bench");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkIdle8("reset8");
    checkOutput("reset8 err",     32'(err8),     32'h0);
    checkOutput("reset8 aborted", 32'(aborted8), 32'h0);
    checkOutput("reset4 busy",    32'(busy4),    32'h0);
    checkOutput("reset4 level",   32'(level4),   32'h0);

    // Full tree.
    run8("ff", 8'hFF, 0, 15'h0001, 15'h0006, 15'h0078, 15'h7F80,
         14'h0003, 14'h003C, 14'h3FC0);

    // Single-leaf path, with an ignored start pulse mid-run.
    run8("m01", 8'h01, 10, 15'h0001, 15'h0002, 15'h0008, 15'h0080,
         14'h0001, 14'h0004, 14'h0040);

    // Empty mask raises err only.
    applyStimulus(1'b1, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("zero err", 32'(err8), 32'h1);
    checkIdle8("zero");
    @(negedge clk);
    checkOutput("zero err clr", 32'(err8), 32'h0);
    checkOutput("zero busy2",   32'(busy8), 32'h0);

    // Abort during depth-2 transfer.
    applyStimulus(1'b1, 8'hFF, 1'b0);
    for (int c = 1; c <= 13; c++) @(negedge clk);
    checkOutput("abort pre xfer",  32'(xfer8),  32'h003C);
    checkOutput("abort pre level", 32'(level8), 32'h2);
    abort8 = 1'b1;
    @(posedge clk);
    #1 abort8 = 1'b0;
    @(negedge clk);
    checkIdle8("abort");
    checkOutput("abort pulse", 32'(aborted8), 32'h1);
    @(negedge clk);
    checkOutput("abort pulse clr", 32'(aborted8), 32'h0);
    checkOutput("abort busy2",     32'(busy8),    32'h0);

    run8("f0", 8'hF0, 0, 15'h0001, 15'h0004, 15'h0060, 15'h7800,
         14'h0002, 14'h0030, 14'h3C00);

    // Start and abort together in IDLE.
    applyStimulus(1'b1, 8'hFF, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkIdle8($sformatf("startabort%0d", k));
      checkOutput($sformatf("startabort%0d err", k),     32'(err8),     32'h0);
      checkOutput($sformatf("startabort%0d aborted", k), 32'(aborted8), 32'h0);
    end

    // Reset in the middle of depth-3 mixing.
    applyStimulus(1'b1, 8'hFF, 1'b0);
    for (int c = 1; c <= 6; c++) @(negedge clk);
    checkOutput("rst pre mix", 32'(mix8), 32'h7F80);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkIdle8("midrst");
    checkOutput("midrst aborted", 32'(aborted8), 32'h0);

    // Four-leaf tree.
    mix4Tab[0] = 7'h01; mix4Tab[1] = 7'h06; mix4Tab[2] = 7'h78;
    xfer4Tab[0] = 6'h00; xfer4Tab[1] = 6'h03; xfer4Tab[2] = 6'h3C;
    @(negedge clk);
    start4 = 1'b1;
    mask4  = 4'hF;
    @(posedge clk);
    #1 start4 = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      expPhase(c, 2, ph, lv);
      checkOutput($sformatf("l4 fill c%0d", c),  32'(fill4),  32'((ph == 1) ? 4'hF : 4'h0));
      checkOutput($sformatf("l4 mix c%0d", c),   32'(mix4),   32'((ph == 2) ? mix4Tab[lv] : 7'h0));
      checkOutput($sformatf("l4 xfer c%0d", c),  32'(xfer4),  32'((ph == 3) ? xfer4Tab[lv] : 6'h0));
      checkOutput($sformatf("l4 drain c%0d", c), 32'(drain4), 32'(ph == 4));
      checkOutput($sformatf("l4 busy c%0d", c),  32'(busy4),  32'(ph != 0));
      checkOutput($sformatf("l4 done c%0d", c),  32'(done4),  32'(ph == 5));
      checkOutput($sformatf("l4 level c%0d", c), 32'(level4), 32'(lv));
    end
    checkOutput("l4 err",     32'(err4),     32'h0);
    checkOutput("l4 aborted", 32'(aborted4), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chamber_tree_sequencer.md
Name: chamber_tree_sequencer

Overview:
Parametrised controller for a binary merge tree of microfluidic chambers. LEAVES leaf chambers fill from one Source and are pairwise mixed and transferred level by level into a single root chamber, which then drains to Out. It generates timed valve-open and mixer-enable vectors for the physical tree. New in this generation: a leaf-select mask to run unbalanced or partial trees, per-phase timing, abort, and status/handshake signals.

Parameters:
LEAVES, 8, number of leaf chambers; power of two, at least 2.
FILL_CYCLES, 4, leaf fill duration; at least 1.
MIX_CYCLES, 3, mix duration per level; at least 1.
XFER_CYCLES, 2, child-to-parent transfer duration; at least 1.
DRAIN_CYCLES, 5, root-to-Out drain duration; at least 1.
CNT_W, 8, phase timer width; must hold max(duration)-1.

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle run request; honoured only in IDLE
leaf_mask  in  LEAVES  leaves to use; sampled with an accepted start
abort  in  1  synchronous abort; cancels the run at the next edge
fill_open  out  LEAVES  Source-to-leaf valves; bit i drives leaf i
mix_on  out  2*LEAVES-1  mixer enable per chamber (heap index)
xfer_open  out  2*LEAVES-2  bit k-1 opens the edge from node k to parent (k-1)/2
drain_open  out  1  root-to-Out valve
busy  out  1  run in progress
level  out  clog2(LEAVES)+1  current tree depth being processed
done  out  1  one-cycle pulse at normal completion
aborted  out  1  one-cycle pulse after abort
err  out  1  one-cycle pulse when start is given with leaf_mask==0

Behaviour:
- Chambers use heap indexing. Node 0 is the root; children of n are 2n+1 and 2n+2. Leaf i is node LEAVES-1+i. Depth D = log2(LEAVES).
- An accepted start latches active[n] = OR of leaf_mask over the leaves under n. Only active nodes get mix, xfer or fill activity.
- States: IDLE, FILL, MIX, XFER, DRAIN, DONE.
- Transitions:
  - IDLE → FILL on an accepted start; level is set to D.
  - FILL → MIX.
  - MIX(level d>0) → XFER(d).
  - XFER(d) → MIX(d-1).
  - MIX(0) → DRAIN.
  - DRAIN → DONE.
  - DONE → IDLE.
- Each timed phase lasts exactly its parameter in cycles. The phase timer loads duration-1 on entry, and the FSM leaves the phase when the timer reads 0. DONE lasts 1 cycle.
- Outputs are Moore, decoded from registered state and active flags. There is no combinational path from any input to any output.
- Output decode by state:
  - FILL: fill_open = leaf_mask as latched.
  - MIX(d): mix_on set for active nodes at depth d.
  - XFER(d): xfer_open set for edges from active depth-d nodes.
  - DRAIN: drain_open=1.
- Timing: start accepted at edge t0 puts FILL in cycles t0+1 .. t0+FILL_CYCLES.
- Total run = FILL + D*(MIX+XFER) + MIX + DRAIN cycles. With defaults this is 27 cycles, and done is high in cycle t0+28.
- busy is high from the cycle after an accepted start through the DONE cycle. done is asserted in the DONE cycle.
- start is ignored while busy. No queuing.
- start with leaf_mask==0 in IDLE: err pulses in the next cycle and the FSM stays in IDLE.
- abort in any non-IDLE state: next cycle is IDLE. All valves and mixers are 0, busy=0, aborted=1 for one cycle. abort in IDLE does nothing.
- abort and start together in IDLE: abort wins and start is dropped.
- Reset (rst_n=0 at an edge), including mid-run: state IDLE and all outputs 0, timer 0, active flags 0, level 0.

Decomposition:
- Package chamber_tree_pkg holds:
  - the state enum;
  - a node-depth function;
  - the function that computes the active vector from leaf_mask;
  - the duration-to-count constants.
- One natural sub-module, phase_timer: a CNT_W loadable down-counter with load, value and zero flag.

Test Plan:
1. LEAVES=8, defaults, mask 8'hFF, start at t0.
   - fill_open=8'hFF for 4 cycles.
   - mix_on bits 7..14 for 3 cycles, then xfer_open bits 6..13 for 2 cycles.
   - Then depths 2 and 1 follow, root mix bit 0, drain_open for 5 cycles.
   - done high at t0+28 only.
2. mask 8'h01.
   - Only nodes 7, 3, 1, 0 mix.
   - Only xfer bits 6, 2, 0 open.
   - fill_open=8'h01.
   - Run length is unchanged: done at t0+28.
3. mask 8'h00 with start.
   - err=1 next cycle, busy stays 0, all outputs 0.
4. abort during XFER at depth 2.
   - Next cycle all outputs are 0 and aborted=1 for one cycle.
   - A subsequent start with 8'hF0 runs normally to done.
5. start pulsed while busy → ignored, and done timing is unchanged. start+abort together in IDLE → remains IDLE with no pulses. rst_n=0 mid-MIX → all outputs 0 the next cycle.
6. LEAVES=4, defaults, mask 4'hF → done at t0+23 (22-cycle run). level steps 2→1→0.
